boreal_mb_arbiter: RTL and testbench
====================================

# boreal_mb_arbiter

Shares one Phase-B request/response mailbox between up to four decision-VM requesters. Each requester gets exclusive ownership of the mailbox for one transaction: eight word writes, `valid_set`, then response handoff and ack. The arbiter sits between the VM instances and the mailbox register block. It grants round-robin, forwards the owner's write strobes with one registered stage, routes the response back to the owner, and recovers from stuck owners or lost responses by timeout.

## Interface
Parameters
- `NREQ`, default 2: number of requesters, legal range 2..4.
- `RESP_TIMEOUT`, default 1024: maximum cycles in WAIT_RESP before forced release.
- `OWN_TIMEOUT`, default 64: maximum cycles in OWNED before forced release.

Ports
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_i` in NREQ: ownership request. The requester holds it high for the whole transaction.
- `gnt_o` out NREQ: one-hot grant, registered.
- `rq_we` in NREQ: per-requester word write strobe.
- `rq_widx` in 4*NREQ: packed word index; requester i uses [4i+3:4i].
- `rq_wdata` in 32*NREQ: packed write data; requester i uses [32i+31:32i].
- `rq_valid_set` in NREQ: per-requester request-commit pulse.
- `rq_resp_valid` out NREQ: response available to the owner.
- `rq_resp_ack` in NREQ: owner's response acknowledge pulse.
- `rq_timeout` out NREQ: one-cycle pulse to the owner on forced release.
- `mb_req_we` out 1, `mb_req_widx` out 4, `mb_req_wdata` out 32, `mb_req_valid_set` out 1: mailbox write side.
- `mb_resp_valid` in 1: mailbox response pending.
- `mb_resp_ack` out 1: mailbox response acknowledge pulse.
- `busy` out 1: high when state is not IDLE.
- `owner_idx` out 2: index of the current or last owner.
- `protocol_err` out 1: sticky error flag, cleared only by reset.
- `orphan_cnt` out 8: saturating count of drained orphan responses.

## Operation
- States: IDLE, OWNED, WAIT_RESP, RELEASE.
- **Arbitration pointer.** `rr` resets to 0. The arbiter searches `req_i` starting at index `rr`, upward modulo NREQ; the first set bit wins.
- **IDLE.**
  - If `mb_resp_valid`=1, the response is an orphan. Pulse `mb_resp_ack`, increment `orphan_cnt` (saturates at 255), and issue no grant that cycle.
  - Otherwise, if any `req_i` is set, set `gnt_o` for the winner, load `owner_idx`, and go to OWNED.
- **OWNED.**
  - Owner's `rq_we`/`rq_widx`/`rq_wdata` are registered onto `mb_req_*`.
  - Owner's `rq_valid_set` is registered onto `mb_req_valid_set`, and the state moves to WAIT_RESP.
  - If owner `req_i` drops without `valid_set`, the transaction aborts: go to RELEASE and forward no `valid_set`.
  - If `valid_set` and `we` arrive in the same cycle, both are forwarded.
- **WAIT_RESP.**
  - `rq_resp_valid[owner] = mb_resp_valid` (combinational, gated by state and grant). All other bits are 0.
  - Owner's `rq_resp_ack` is registered onto `mb_resp_ack`, and the state moves to RELEASE on the same edge.
  - Owner strobes (`we`, `valid_set`) are dropped and set `protocol_err`.
  - `req_i` dropping is ignored here.
- **RELEASE.** One cycle. Clear `gnt_o`, set `rr = (owner_idx+1) mod NREQ`, go to IDLE.
- **Timeouts.** A 16-bit counter clears on every state entry. The counter reaching OWN_TIMEOUT in OWNED, or RESP_TIMEOUT in WAIT_RESP, causes:
  - a `rq_timeout[owner]` pulse,
  - no `mb_resp_ack`,
  - a transition to RELEASE.

  A late response to a timed-out transaction is drained as an orphan from IDLE.
- **Non-owner strobes.** Any `rq_we` or `rq_valid_set` from a non-owner, or any strobe arriving in IDLE/RELEASE, is dropped and sets `protocol_err`.
- **Reset values.**
  - `gnt_o`, `rq_timeout`, `mb_req_we`, `mb_req_widx`, `mb_req_wdata`, `mb_req_valid_set`, `mb_resp_ack`, `busy`, `owner_idx`, `protocol_err`, `orphan_cnt`: all 0.
  - State IDLE, `rr`=0.
  - A reset mid-transaction abandons it. No ack is issued, and any response still pending is drained as an orphan after reset.

## Timing
- Grant latency: `req_i` rises in cycle 0, `gnt_o` is high in cycle 1.
- Write forwarding: requester strobe in cycle k appears on `mb_req_*` in cycle k+1.
- `valid_set` in cycle k: `mb_req_valid_set` pulses in cycle k+1; state is WAIT_RESP from k+1.
- Response: `rq_resp_valid` follows `mb_resp_valid` in the same cycle.
- Ack in cycle k: `mb_resp_ack` in cycle k+1; state is RELEASE in k+1 and `gnt_o` is 0 in k+2.
- Back-to-back: the earliest next grant is 3 cycles after the ack (RELEASE, then IDLE evaluation).
- All outputs are registered except `rq_resp_valid`.

## Test plan
- **Single transaction.** NREQ=2. Requester 0 requests at cycle 0 → `gnt_o`=01 at cycle 1. It writes words 0..7 (word2=100, word5=0xA5A50001); each appears on `mb_req_*` one cycle later. Then `valid_set`; bench asserts `mb_resp_valid`; requester acks → `mb_resp_ack` pulses once, `gnt_o`=00 two cycles after the ack, `rr`=1.
- **Simultaneous requests.** Both `req_i` rise in the same cycle → requester 0 is granted first, requester 1 is granted after release. Repeating the pair → requester 1 is granted first.
- **Intruder write.** With requester 0 owning, requester 1 pulses `rq_we` with index 3, data 0xDEAD → no `mb_req_we` for that write, `protocol_err`=1.
- **Response timeout.** RESP_TIMEOUT=16 and no response after `valid_set` → `rq_timeout[0]` pulses 16 cycles into WAIT_RESP, no `mb_resp_ack`. A later `mb_resp_valid` in IDLE → `mb_resp_ack` pulse, `orphan_cnt`=1.
- **Abort.** The owner drops `req_i` after 3 writes → no `mb_req_valid_set`, state is IDLE 2 cycles later, and the other requester is granted next.
- **Reset mid-transaction.** `rst_n` is low for 1 cycle during WAIT_RESP → all outputs are 0 the next cycle. A still-pending `mb_resp_valid` is drained as an orphan.

Source files
------------

// File: rtl/boreal_mb_arbiter.sv
// Round-robin owner arbiter for the shared Phase-B mailbox: one requester at a time
// writes its request words, commits with valid_set, and collects the response.
`timescale 1ns/1ps
module boreal_mb_arbiter #(
  parameter int NREQ         = 2,
  parameter int RESP_TIMEOUT = 1024,
  parameter int OWN_TIMEOUT  = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_i,
  output logic [NREQ-1:0]      gnt_o,
  input  logic [NREQ-1:0]      rq_we,
  input  logic [4*NREQ-1:0]    rq_widx,
  input  logic [32*NREQ-1:0]   rq_wdata,
  input  logic [NREQ-1:0]      rq_valid_set,
  output logic [NREQ-1:0]      rq_resp_valid,
  input  logic [NREQ-1:0]      rq_resp_ack,
  output logic [NREQ-1:0]      rq_timeout,
  output logic                 mb_req_we,
  output logic [3:0]           mb_req_widx,
  output logic [31:0]          mb_req_wdata,
  output logic                 mb_req_valid_set,
  input  logic                 mb_resp_valid,
  output logic                 mb_resp_ack,
  output logic                 busy,
  output logic [1:0]           owner_idx,
  output logic                 protocol_err,
  output logic [7:0]           orphan_cnt,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWNED = 2'd1,
    S_WAIT  = 2'd2,
    S_REL   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] to_q, to_d;
  logic [1:0]      rr_q, rr_d;
  logic [1:0]      owner_q, owner_d;
  logic            we_q, we_d;
  logic [3:0]      widx_q, widx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            vset_q, vset_d;
  logic            ack_q, ack_d;
  logic            busy_q, busy_d;
  logic            perr_q, perr_d;
  logic [7:0]      orphan_q, orphan_d;
  logic [15:0]     cnt_q, cnt_d;

  logic            any_req;
  logic [NREQ-1:0] win_onehot;
  logic [1:0]      win_idx;
  logic            win_found;
  int              cand;
  logic            own_req, own_we, own_vset, own_ack;
  logic [3:0]      own_widx;
  logic [31:0]     own_wdata;
  logic [NREQ-1:0] strobes;
  logic            perr_set;
  logic            own_to, resp_to;

  assign any_req  = |req_i;
  assign own_req  = |(req_i & gnt_q);
  assign own_we   = |(rq_we & gnt_q);
  assign own_vset = |(rq_valid_set & gnt_q);
  assign own_ack  = |(rq_resp_ack & gnt_q);
  assign own_to   = (cnt_q == 16'(OWN_TIMEOUT - 1));
  assign resp_to  = (cnt_q == 16'(RESP_TIMEOUT - 1));
  assign strobes  = rq_we | rq_valid_set;

  // Round-robin search starting at rr, wrapping modulo NREQ.
  always_comb begin
    win_found  = 1'b0;
    win_onehot = '0;
    win_idx    = '0;
    cand       = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(rr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!win_found && req_i[cand]) begin
        win_found        = 1'b1;
        win_onehot[cand] = 1'b1;
        win_idx          = 2'(cand);
      end
    end
  end

  always_comb begin
    own_widx  = '0;
    own_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) begin
        own_widx  = rq_widx[4*i +: 4];
        own_wdata = rq_wdata[32*i +: 32];
      end
    end
  end

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      to_q     <= '0;
      rr_q     <= '0;
      owner_q  <= '0;
      we_q     <= 1'b0;
      widx_q   <= '0;
      wdata_q  <= '0;
      vset_q   <= 1'b0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      perr_q   <= 1'b0;
      orphan_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      to_q     <= to_d;
      rr_q     <= rr_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      widx_q   <= widx_d;
      wdata_q  <= wdata_d;
      vset_q   <= vset_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      perr_q   <= perr_d;
      orphan_q <= orphan_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state: valid_set outranks an abort or timeout landing in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!mb_resp_valid && any_req) state_d = S_OWNED;
      S_OWNED: begin
        if (own_vset)      state_d = S_WAIT;
        else if (!own_req) state_d = S_REL;
        else if (own_to)   state_d = S_REL;
      end
      S_WAIT:  if (own_ack || resp_to) state_d = S_REL;
      default: state_d = S_IDLE;
    endcase
  end

  // Mailbox response handshake: mb_resp_valid stays high until the mailbox sees
  // our one-cycle mb_resp_ack, so a valid seen while ack_q is high is the same response.
  always_comb begin
    gnt_d    = gnt_q;
    to_d     = '0;
    rr_d     = rr_q;
    owner_d  = owner_q;
    we_d     = 1'b0;
    widx_d   = widx_q;
    wdata_d  = wdata_q;
    vset_d   = 1'b0;
    ack_d    = 1'b0;
    orphan_d = orphan_q;
    perr_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        perr_set = |strobes;
        if (mb_resp_valid) begin
          if (!ack_q) begin
            ack_d = 1'b1;
            if (orphan_q != 8'hFF) orphan_d = orphan_q + 8'd1;
          end
        end else if (win_found) begin
          gnt_d   = win_onehot;
          owner_d = win_idx;
        end
      end
      S_OWNED: begin
        perr_set = |(strobes & ~gnt_q);
        we_d     = own_we;
        vset_d   = own_vset;
        if (own_we) begin
          widx_d  = own_widx;
          wdata_d = own_wdata;
        end
        if (!own_vset && own_req && own_to) to_d = gnt_q;
      end
      S_WAIT: begin
        perr_set = |strobes;
        if (own_ack)      ack_d = 1'b1;
        else if (resp_to) to_d  = gnt_q;
      end
      default: begin
        perr_set = |strobes;
        gnt_d    = '0;
        rr_d     = (owner_q == 2'(NREQ - 1)) ? 2'd0 : owner_q + 2'd1;
      end
    endcase
    perr_d = perr_q | perr_set;
    busy_d = (state_d != S_IDLE);
    if (state_d != state_q)    cnt_d = '0;
    else if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    else                        cnt_d = cnt_q;
  end

  assign rq_resp_valid    = (state_q == S_WAIT) ? (gnt_q & {NREQ{mb_resp_valid}}) : '0;
  assign gnt_o            = gnt_q;
  assign rq_timeout       = to_q;
  assign mb_req_we        = we_q;
  assign mb_req_widx      = widx_q;
  assign mb_req_wdata     = wdata_q;
  assign mb_req_valid_set = vset_q;
  assign mb_resp_ack      = ack_q;
  assign busy             = busy_q;
  assign owner_idx        = owner_q;
  assign protocol_err     = perr_q;
  assign orphan_cnt       = orphan_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_boreal_mb_arbiter.sv
// Directed bench for boreal_mb_arbiter: arbitration order, write forwarding,
// intruder/abort handling, response timeout, orphan drain and reset recovery.
`timescale 1ns/1ps
module tb_boreal_mb_arbiter;
  localparam int NREQ = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_i, gnt_o, rq_we, rq_valid_set, rq_resp_valid, rq_resp_ack, rq_timeout;
  logic [4*NREQ-1:0]   rq_widx;
  logic [32*NREQ-1:0]  rq_wdata;
  logic                mb_req_we, mb_req_valid_set, mb_resp_valid, mb_resp_ack, busy, protocol_err;
  logic [3:0]          mb_req_widx;
  logic [31:0]         mb_req_wdata;
  logic [1:0]          owner_idx, state_o;
  logic [7:0]          orphan_cnt;

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;
  logic [35:0] exp_q[$];
  logic [35:0] exp_w;

  boreal_mb_arbiter #(.NREQ(NREQ), .RESP_TIMEOUT(16), .OWN_TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .gnt_o(gnt_o),
    .rq_we(rq_we), .rq_widx(rq_widx), .rq_wdata(rq_wdata),
    .rq_valid_set(rq_valid_set), .rq_resp_valid(rq_resp_valid),
    .rq_resp_ack(rq_resp_ack), .rq_timeout(rq_timeout),
    .mb_req_we(mb_req_we), .mb_req_widx(mb_req_widx), .mb_req_wdata(mb_req_wdata),
    .mb_req_valid_set(mb_req_valid_set), .mb_resp_valid(mb_resp_valid),
    .mb_resp_ack(mb_resp_ack), .busy(busy), .owner_idx(owner_idx),
    .protocol_err(protocol_err), .orphan_cnt(orphan_cnt), .state_o(state_o)
  );

  // Clock / time limit
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  // Scoreboard: every forwarded mailbox write must match the next queued one.
  always @(negedge clk) begin
    if (rst_n && mb_req_we) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_write: observed idx %0h data %0h, expected no write", mb_req_widx, mb_req_wdata);
      end
      if (exp_q.size() > 0) begin
        exp_w = exp_q.pop_front();
        checks++;
        assert ({mb_req_widx, mb_req_wdata} === exp_w) else begin
          errors++;
          $error("FAIL write_data: observed %h expected %h", {mb_req_widx, mb_req_wdata}, exp_w);
        end
      end
    end
    if (rst_n && mb_resp_ack) ack_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic drive_write(input int r, input logic [3:0] idx, input logic [31:0] d);
    rq_we[r]             = 1'b1;
    rq_widx[4*r +: 4]    = idx;
    rq_wdata[32*r +: 32] = d;
    exp_q.push_back({idx, d});
    step();
    rq_we = '0;
  endtask

  task automatic commit(input int r);
    rq_valid_set[r] = 1'b1;
    step();
    rq_valid_set = '0;
    chk("valid_set_fwd", 32'(mb_req_valid_set), 32'd1);
    chk("state_wait", 32'(state_o), 32'd2);
  endtask

  task automatic respond_ack(input int r);
    mb_resp_valid = 1'b1;
    #1;
    chk("resp_route", 32'(rq_resp_valid), 32'(1 << r));
    rq_resp_ack[r] = 1'b1;
    step();
    rq_resp_ack   = '0;
    mb_resp_valid = 1'b0;
    chk("resp_ack", 32'(mb_resp_ack), 32'd1);
    chk("state_release", 32'(state_o), 32'd3);
    chk("gnt_held_release", 32'(gnt_o), 32'(1 << r));
    req_i[r] = 1'b0;
    step();
    chk("resp_ack_pulse", 32'(mb_resp_ack), 32'd0);
    chk("gnt_cleared", 32'(gnt_o), 32'd0);
    chk("state_idle", 32'(state_o), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_i = '0; rq_we = '0; rq_widx = '0; rq_wdata = '0;
    rq_valid_set = '0; rq_resp_ack = '0; mb_resp_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_owner", 32'(owner_idx), 32'd0);
    chk("rst_perr", 32'(protocol_err), 32'd0);
    chk("rst_orphan", 32'(orphan_cnt), 32'd0);
    chk("rst_we", 32'(mb_req_we), 32'd0);
    chk("rst_state", 32'(state_o), 32'd0);

    // Simultaneous requests from rr=0: 0 then 1
    req_i = 2'b11;
    step();
    chk("sim1_gnt0", 32'(gnt_o), 32'h1);
    chk("sim1_busy", 32'(busy), 32'd1);
    chk("sim1_owner0", 32'(owner_idx), 32'd0);
    commit(0);
    respond_ack(0);
    step();
    chk("sim1_gnt1", 32'(gnt_o), 32'h2);
    chk("sim1_owner1", 32'(owner_idx), 32'd1);
    commit(1);
    respond_ack(1);

    // Single transaction, eight words
    req_i = 2'b01;
    step();
    chk("single_gnt", 32'(gnt_o), 32'h1);
    for (int w = 0; w < 8; w++) begin
      if (w == 2)      drive_write(0, 4'(w), 32'd100);
      else if (w == 5) drive_write(0, 4'(w), 32'hA5A5_0001);
      else             drive_write(0, 4'(w), $urandom);
    end
    commit(0);
    chk("single_drained", 32'(exp_q.size()), 32'd0);
    step();
    chk("vset_pulse", 32'(mb_req_valid_set), 32'd0);
    respond_ack(0);

    // Simultaneous again with rr=1: 1 first
    req_i = 2'b11;
    step();
    chk("sim2_gnt1", 32'(gnt_o), 32'h2);
    commit(1);
    respond_ack(1);
    step();
    chk("sim2_gnt0", 32'(gnt_o), 32'h1);
    commit(0);
    respond_ack(0);

    // Intruder write while requester 0 owns
    req_i = 2'b01;
    step();
    chk("intr_gnt", 32'(gnt_o), 32'h1);
    chk("intr_perr_before", 32'(protocol_err), 32'd0);
    rq_we[1] = 1'b1; rq_widx[7:4] = 4'd3; rq_wdata[63:32] = 32'hDEAD;
    step();
    rq_we = '0;
    chk("intr_no_we", 32'(mb_req_we), 32'd0);
    chk("intr_perr", 32'(protocol_err), 32'd1);
    drive_write(0, 4'd7, 32'h1234_5678);
    commit(0);
    respond_ack(0);

    // Response timeout, then late response drained as orphan
    req_i = 2'b01;
    step();
    chk("to_gnt", 32'(gnt_o), 32'h1);
    commit(0);
    for (int i = 1; i < 16; i++) begin
      step();
      chk("to_early", 32'(rq_timeout), 32'd0);
    end
    step();
    chk("to_pulse", 32'(rq_timeout), 32'h1);
    chk("to_state", 32'(state_o), 32'd3);
    chk("to_no_ack", 32'(mb_resp_ack), 32'd0);
    req_i = '0;
    step();
    chk("to_pulse_end", 32'(rq_timeout), 32'd0);
    chk("to_idle", 32'(state_o), 32'd0);
    mb_resp_valid = 1'b1;
    step();
    mb_resp_valid = 1'b0;
    chk("orphan_ack", 32'(mb_resp_ack), 32'd1);
    chk("orphan_cnt1", 32'(orphan_cnt), 32'd1);
    chk("orphan_no_gnt", 32'(gnt_o), 32'd0);
    step();
    chk("orphan_ack_pulse", 32'(mb_resp_ack), 32'd0);

    // Abort: owner 0 drops req after 3 writes, requester 1 waiting
    req_i = 2'b01;
    step();
    chk("abort_gnt0", 32'(gnt_o), 32'h1);
    req_i = 2'b11;
    for (int w = 0; w < 3; w++) drive_write(0, 4'(w), $urandom);
    req_i[0] = 1'b0;
    step();
    chk("abort_release", 32'(state_o), 32'd3);
    chk("abort_no_vset", 32'(mb_req_valid_set), 32'd0);
    step();
    chk("abort_idle", 32'(state_o), 32'd0);
    chk("abort_no_vset2", 32'(mb_req_valid_set), 32'd0);
    step();
    chk("abort_gnt1", 32'(gnt_o), 32'h2);
    commit(1);
    respond_ack(1);

    // Reset during WAIT_RESP with a response pending
    req_i = 2'b01;
    step();
    chk("rst2_gnt", 32'(gnt_o), 32'h1);
    commit(0);
    mb_resp_valid = 1'b1;
    rst_n = 1'b0;
    req_i = '0;
    step();
    rst_n = 1'b1;
    chk("rst2_gnt0", 32'(gnt_o), 32'd0);
    chk("rst2_busy", 32'(busy), 32'd0);
    chk("rst2_perr", 32'(protocol_err), 32'd0);
    chk("rst2_ack", 32'(mb_resp_ack), 32'd0);
    chk("rst2_state", 32'(state_o), 32'd0);
    chk("rst2_orphan", 32'(orphan_cnt), 32'd0);
    chk("rst2_wdata", mb_req_wdata, 32'd0);
    chk("rst2_resp_valid", 32'(rq_resp_valid), 32'd0);
    step();
    mb_resp_valid = 1'b0;
    chk("rst2_drain_ack", 32'(mb_resp_ack), 32'd1);
    chk("rst2_orphan1", 32'(orphan_cnt), 32'd1);
    step();
    step();

    chk("total_acks", 32'(ack_cnt), 32'd9);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
